io_out_bank: RTL and testbench

- Parametrised successor to the single 8-bit output register driven by c_go.
- Provides CHANNELS independent output ports, each with a DEPTH-entry FIFO and a valid/ready handshake to the external device.
- Sits on the CPU data bus next to the register file. The Signal-Controller's c_go strobe plus a channel select push bus data into a channel FIFO.
- Reports a stall request so the clock block can halt the core when the target FIFO is full.

---
 rtl/io_out_bank.sv | 165 ++++++++++++++++
 tb/tb_io_out_bank.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_out_bank.sv
// io_out_bank: CHANNELS independent output ports, each fed by a DEPTH-entry
// FIFO. The core pushes bus data into a channel with c_go plus a channel
// select. The external device drains each channel with a valid/ready
// handshake.
// A write aimed at a full channel that is not being drained raises a
// combinational stall request. If the write is forced through anyway, the
// data is dropped and the channel's sticky overflow flag is set.
module io_out_bank #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    parameter int SEL_W    = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         c_go,
    input  logic [SEL_W-1:0]             sel,
    input  logic [DATA_W-1:0]            idata,
    input  logic                         c_clr,
    output logic [CHANNELS*DATA_W-1:0]   oport,
    output logic [CHANNELS-1:0]          ovalid,
    input  logic [CHANNELS-1:0]          oready,
    output logic [CHANNELS-1:0]          full,
    output logic [CHANNELS-1:0]          overflow,
    output logic                         stall,
    output logic                         bad_sel
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]         sel_ext_s;
    logic                sel_ok_s;
    logic [CHANNELS-1:0] sel_hit_s;
    logic [CHANNELS-1:0] full_s;
    logic                stall_s;
    logic                bad_sel_r;

    // Widen the select so that range checks also work when 2**SEL_W > CHANNELS.
    always_comb begin
        sel_ext_s = 32'(sel);
        if (sel_ext_s < 32'(CHANNELS)) begin
            sel_ok_s = 1'b1;
        end else begin
            sel_ok_s = 1'b0;
        end
    end

    // Stall only when the addressed channel is full and will not drain on this edge.
    always_comb begin
        stall_s = |(sel_hit_s & full_s & ~oready);
    end

    assign stall   = stall_s;
    assign full    = full_s;
    assign bad_sel = bad_sel_r;

    // One-cycle flag for a write strobe that names a non-existent channel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bad_sel_r <= 1'b0;
        end else begin
            bad_sel_r <= c_go & ~sel_ok_s;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [DATA_W-1:0] mem_r [DEPTH];
        logic [PTR_W-1:0]  wptr_r;
        logic [PTR_W-1:0]  rptr_r;
        logic [PTR_W-1:0]  rptr_nx_s;
        logic [CNT_W-1:0]  cnt_r;
        logic [CNT_W-1:0]  cnt_nx_s;
        logic [DATA_W-1:0] head_r;
        logic [DATA_W-1:0] head_nx_s;
        logic              valid_r;
        logic              full_r;
        logic              ovf_r;
        logic              ovf_nx_s;
        logic              pop_s;
        logic              push_s;
        logic              drop_s;

        assign sel_hit_s[k] = c_go & (sel_ext_s == 32'(k));

        // Handshake decode, next count/pointer and the head value for the next cycle.
        always_comb begin
            pop_s  = valid_r & oready[k];
            push_s = sel_hit_s[k] & ((cnt_r != FULL_CNT) | pop_s);
            drop_s = sel_hit_s[k] & (cnt_r == FULL_CNT) & ~pop_s;

            if (pop_s) begin
                rptr_nx_s = rptr_r + PTR_W'(1);
            end else begin
                rptr_nx_s = rptr_r;
            end

            if (push_s && !pop_s) begin
                cnt_nx_s = cnt_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                cnt_nx_s = cnt_r - CNT_W'(1);
            end else begin
                cnt_nx_s = cnt_r;
            end

            // The new head is the incoming word when it lands in the slot about to be
            // read. This happens when writing into an empty FIFO, or when pushing and
            // popping together with a single entry.
            if (push_s && (rptr_nx_s == wptr_r)) begin
                head_nx_s = idata;
            end else begin
                head_nx_s = mem_r[rptr_nx_s];
            end

            // A fresh drop beats a simultaneous clear.
            if (drop_s) begin
                ovf_nx_s = 1'b1;
            end else if (c_clr) begin
                ovf_nx_s = 1'b0;
            end else begin
                ovf_nx_s = ovf_r;
            end
        end

        // FIFO storage. The contents are meaningless until written, so the array has no reset.
        always_ff @(posedge clk) begin
            if (push_s) begin
                mem_r[wptr_r] <= idata;
            end
        end

        // Pointers, occupancy and the registered per-channel outputs.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wptr_r  <= {PTR_W{1'b0}};
                rptr_r  <= {PTR_W{1'b0}};
                cnt_r   <= {CNT_W{1'b0}};
                head_r  <= {DATA_W{1'b0}};
                valid_r <= 1'b0;
                full_r  <= 1'b0;
                ovf_r   <= 1'b0;
            end else begin
                if (push_s) begin
                    wptr_r <= wptr_r + PTR_W'(1);
                end
                rptr_r  <= rptr_nx_s;
                cnt_r   <= cnt_nx_s;
                valid_r <= (cnt_nx_s != {CNT_W{1'b0}});
                full_r  <= (cnt_nx_s == FULL_CNT);
                ovf_r   <= ovf_nx_s;
                // When the FIFO empties, the port keeps showing the last word popped.
                if (cnt_nx_s != {CNT_W{1'b0}}) begin
                    head_r <= head_nx_s;
                end
            end
        end

        assign oport[k*DATA_W +: DATA_W] = head_r;
        assign ovalid[k]                 = valid_r;
        assign full_s[k]                 = full_r;
        assign overflow[k]               = ovf_r;
    end

endmodule

// File: tb/tb_io_out_bank.sv
// Directed bench for io_out_bank. A vector table covers the single-cycle
// behaviour. Hand-written sequences cover pointer wrap, invalid select and
// asynchronous reset.
module tb_io_out_bank;

    logic        clk;
    logic        reset;
    logic        c_go;
    logic [1:0]  sel;
    logic [7:0]  idata;
    logic        c_clr;
    logic [31:0] oport;
    logic [3:0]  ovalid;
    logic [3:0]  oready;
    logic [3:0]  full;
    logic [3:0]  overflow;
    logic        stall;
    logic        bad_sel;

    // Second instance with three channels, so that sel = 3 is out of range.
    logic        c_go3;
    logic [1:0]  sel3;
    logic [7:0]  idata3;
    logic        c_clr3;
    logic [23:0] oport3;
    logic [2:0]  ovalid3;
    logic [2:0]  oready3;
    logic [2:0]  full3;
    logic [2:0]  overflow3;
    logic        stall3;
    logic        bad_sel3;

    int total;
    int bad;

    io_out_bank #(.DATA_W(8), .CHANNELS(4), .DEPTH(4), .SEL_W(2)) u_dut (
        .clk(clk), .reset(reset), .c_go(c_go), .sel(sel), .idata(idata),
        .c_clr(c_clr), .oport(oport), .ovalid(ovalid), .oready(oready),
        .full(full), .overflow(overflow), .stall(stall), .bad_sel(bad_sel)
    );

    io_out_bank #(.DATA_W(8), .CHANNELS(3), .DEPTH(4), .SEL_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .c_go(c_go3), .sel(sel3), .idata(idata3),
        .c_clr(c_clr3), .oport(oport3), .ovalid(ovalid3), .oready(oready3),
        .full(full3), .overflow(overflow3), .stall(stall3), .bad_sel(bad_sel3)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        go;
        logic [1:0]  s;
        logic [7:0]  d;
        logic [3:0]  rdy;
        logic        clr;
        logic        e_stall;
        logic [3:0]  e_valid;
        logic [3:0]  e_full;
        logic [3:0]  e_ovf;
        logic [31:0] e_port;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic go, input logic [1:0] s, input logic [7:0] d,
                                input logic [3:0] rdy, input logic clr, input logic e_stall,
                                input logic [3:0] e_valid, input logic [3:0] e_full,
                                input logic [3:0] e_ovf, input logic [31:0] e_port);
        vec_t v;
        v.go = go; v.s = s; v.d = d; v.rdy = rdy; v.clr = clr;
        v.e_stall = e_stall; v.e_valid = e_valid; v.e_full = e_full;
        v.e_ovf = e_ovf; v.e_port = e_port;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int v;
        int n;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        c_go = 1'b0; sel = 2'd0; idata = 8'h00; c_clr = 1'b0; oready = 4'b0000;
        c_go3 = 1'b0; sel3 = 2'd0; idata3 = 8'h00; c_clr3 = 1'b0; oready3 = 3'b000;

        // Vector table: inputs held for one edge, stall checked before the edge,
        // registered outputs checked after it.
        vecs.push_back(mk(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h00A50000));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 32'h00A50000));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00A50000));
        vecs.push_back(mk(1'b1, 2'd0, 8'h01, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00A50001));
        vecs.push_back(mk(1'b1, 2'd0, 8'h02, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00A50001));
        vecs.push_back(mk(1'b1, 2'd0, 8'h03, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 32'h00A50001));
        vecs.push_back(mk(1'b1, 2'd0, 8'h04, 4'b0000, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 32'h00A50001));
        vecs.push_back(mk(1'b1, 2'd0, 8'h05, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0001, 32'h00A50001));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 32'h00A50002));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 32'h00A50003));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0001, 32'h00A50004));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0001, 32'h00A50004));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00A50004));
        vecs.push_back(mk(1'b1, 2'd1, 8'h10, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 32'h00A51004));
        vecs.push_back(mk(1'b1, 2'd1, 8'h11, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 32'h00A51004));
        vecs.push_back(mk(1'b1, 2'd1, 8'h12, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 32'h00A51004));
        vecs.push_back(mk(1'b1, 2'd1, 8'h13, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 32'h00A51004));
        vecs.push_back(mk(1'b1, 2'd1, 8'h14, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 32'h00A51104));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 32'h00A51204));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 32'h00A51304));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 32'h00A51404));
        vecs.push_back(mk(1'b0, 2'd0, 8'h00, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 32'h00A51404));

        // Reset held for two cycles, then released between edges.
        tick();
        tick();
        chk("rst_ovalid", 32'(ovalid), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_bad_sel", 32'(bad_sel), 32'h0);
        chk("rst_oport", oport, 32'h0);
        reset = 1'b1;
        tick();

        foreach (vecs[i]) begin
            c_go = vecs[i].go; sel = vecs[i].s; idata = vecs[i].d;
            oready = vecs[i].rdy; c_clr = vecs[i].clr;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            tick();
            chk($sformatf("v%0d_ovalid", i), 32'(ovalid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
            chk($sformatf("v%0d_oport", i), oport, vecs[i].e_port);
        end
        c_go = 1'b0; oready = 4'b0000; c_clr = 1'b0;

        // Pointer wrap on channel 3: bursts of up to three pushes, each followed by a full drain.
        v = 0;
        while (v < 10) begin
            n = (10 - v > 3) ? 3 : 10 - v;
            for (int i = 0; i < n; i++) begin
                c_go = 1'b1; sel = 2'd3; idata = 8'(32'h20 + v + i);
                tick();
            end
            c_go = 1'b0;
            for (int i = 0; i < n; i++) begin
                chk($sformatf("wrap_valid_%0d", v + i), 32'(ovalid[3]), 32'h1);
                chk($sformatf("wrap_data_%0d", v + i), 32'(oport[31:24]), 32'h20 + 32'(v + i));
                oready = 4'b1000;
                tick();
                oready = 4'b0000;
            end
            v = v + n;
        end
        chk("wrap_empty", 32'(ovalid[3]), 32'h0);

        // Push and pop together while holding a single entry.
        c_go = 1'b1; sel = 2'd3; idata = 8'h30;
        tick();
        idata = 8'h31; oready = 4'b1000;
        tick();
        c_go = 1'b0; oready = 4'b0000;
        chk("one_pp_valid", 32'(ovalid[3]), 32'h1);
        chk("one_pp_data", 32'(oport[31:24]), 32'h31);
        oready = 4'b1000;
        tick();
        oready = 4'b0000;
        chk("one_pp_empty", 32'(ovalid[3]), 32'h0);
        chk("one_pp_hold", 32'(oport[31:24]), 32'h31);

        // Pops on two channels in the same cycle.
        c_go = 1'b1; sel = 2'd0; idata = 8'h60;
        tick();
        sel = 2'd1; idata = 8'h61;
        tick();
        c_go = 1'b0;
        chk("multi_valid", 32'(ovalid), 32'h3);
        chk("multi_port", 32'(oport[15:0]), 32'h6160);
        oready = 4'b0011;
        tick();
        oready = 4'b0000;
        chk("multi_popped", 32'(ovalid), 32'h0);

        // Asynchronous reset mid-operation, with full and overflow both set.
        for (int i = 0; i < 3; i++) begin
            c_go = 1'b1; sel = 2'd2; idata = 8'(32'h40 + i);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            c_go = 1'b1; sel = 2'd0; idata = 8'(32'h01 + i);
            tick();
        end
        c_go = 1'b0;
        chk("pre_rst_valid", 32'(ovalid), 32'h5);
        chk("pre_rst_full", 32'(full), 32'h1);
        chk("pre_rst_ovf", 32'(overflow), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ovalid", 32'(ovalid), 32'h0);
        chk("arst_full", 32'(full), 32'h0);
        chk("arst_overflow", 32'(overflow), 32'h0);
        chk("arst_oport", oport, 32'h0);
        #1;
        reset = 1'b1;
        tick();
        c_go = 1'b1; sel = 2'd2; idata = 8'h50;
        tick();
        c_go = 1'b0;
        chk("post_rst_valid", 32'(ovalid), 32'h4);
        chk("post_rst_port", oport, 32'h00500000);
        oready = 4'b0100;
        tick();
        oready = 4'b0000;
        chk("post_rst_alone", 32'(ovalid), 32'h0);

        // Three-channel instance: an out-of-range select, then clear racing an overflow.
        c_go3 = 1'b1; sel3 = 2'd1; idata3 = 8'h77;
        tick();
        c_go3 = 1'b0;
        chk("c3_valid", 32'(ovalid3), 32'h2);
        chk("c3_port", 32'(oport3), 32'h007700);
        c_go3 = 1'b1; sel3 = 2'd3; idata3 = 8'hEE;
        #1;
        chk("c3_bad_stall", 32'(stall3), 32'h0);
        tick();
        c_go3 = 1'b0;
        chk("c3_bad_sel", 32'(bad_sel3), 32'h1);
        chk("c3_bad_valid", 32'(ovalid3), 32'h2);
        chk("c3_bad_full", 32'(full3), 32'h0);
        chk("c3_bad_port", 32'(oport3), 32'h007700);
        tick();
        chk("c3_bad_pulse", 32'(bad_sel3), 32'h0);
        chk("c3_bad_valid2", 32'(ovalid3), 32'h2);
        for (int i = 0; i < 4; i++) begin
            c_go3 = 1'b1; sel3 = 2'd0; idata3 = 8'(32'h81 + i);
            tick();
        end
        chk("c3_full", 32'(full3), 32'h1);
        chk("c3_head", 32'(oport3), 32'h007781);
        c_go3 = 1'b1; sel3 = 2'd0; idata3 = 8'h85; c_clr3 = 1'b1;
        #1;
        chk("c3_stall", 32'(stall3), 32'h1);
        tick();
        c_go3 = 1'b0;
        chk("c3_ovf_wins", 32'(overflow3), 32'h1);
        tick();
        c_clr3 = 1'b0;
        chk("c3_clr", 32'(overflow3), 32'h0);
        chk("c3_head_kept", 32'(oport3), 32'h007781);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
